// File: rtl/nibble_serial_comparator_pkg.sv
// Shared types and constants for the nibble-serial magnitude comparator.
//   state_e          : controller states
//   CAS_LT/EQ/GT     : bit positions inside the {lt,eq,gt} cascade triple
//   NIB_W            : width of one processed digit
package nsc_pkg;

  localparam int unsigned NIB_W  = 4;

  localparam int unsigned CAS_LT = 2;
  localparam int unsigned CAS_EQ = 1;
  localparam int unsigned CAS_GT = 0;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/nibble_serial_comparator_if.sv
// Request/result bundle of the nibble-serial comparator.
//   master : requester (drives start, operands, cascade seeds)
//   slave  : comparator (drives busy, done and the lt/eq/gt result)
interface nibble_serial_comparator_if #(
  parameter int unsigned NIBBLES = 4
) ();

  localparam int unsigned OP_W = nsc_pkg::NIB_W * NIBBLES;

  logic            start;
  logic [OP_W-1:0] a;
  logic [OP_W-1:0] b;
  logic            seed_eq;
  logic            seed_lt;
  logic            seed_gt;
  logic            busy;
  logic            done;
  logic            eq_out;
  logic            lt_out;
  logic            gt_out;

  modport master (
    output start, a, b, seed_eq, seed_lt, seed_gt,
    input  busy, done, eq_out, lt_out, gt_out
  );

  modport slave (
    input  start, a, b, seed_eq, seed_lt, seed_gt,
    output busy, done, eq_out, lt_out, gt_out
  );

endinterface

// File: rtl/nibble_serial_comparator_cmp4.sv
// Combinational 4-bit unsigned magnitude compare with one-hot result.
//   an, bn           : nibbles to compare
//   lt_c, eq_c, gt_c : an<bn, an==bn, an>bn (exactly one is high)
module nibble_cmp4
  import nsc_pkg::*;
(
  input  logic [NIB_W-1:0] an,
  input  logic [NIB_W-1:0] bn,
  output logic             lt_c,
  output logic             eq_c,
  output logic             gt_c
);

  always_comb begin
    lt_c = 1'b0;
    eq_c = 1'b0;
    gt_c = 1'b0;
    if (an > bn)      gt_c = 1'b1;
    else if (an < bn) lt_c = 1'b1;
    else              eq_c = 1'b1;
  end

endmodule

// File: rtl/nibble_serial_comparator.sv
// Multi-cycle unsigned magnitude comparator: walks the operands one nibble per
// clock, LSB nibble first, carrying a registered {lt,eq,gt} cascade. Later
// (higher) nibbles overwrite earlier ones, so the most-significant unequal
// nibble decides; if every nibble is equal the seed passes through untouched.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : start/operands/seeds in, busy/done/lt/eq/gt out
module nibble_serial_comparator
  import nsc_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input logic                         clk,
  input logic                         rst_n,
  nibble_serial_comparator_if.slave   bus
);

  localparam int unsigned OP_W  = NIB_W * NIBBLES;
  localparam int unsigned CNT_W = $clog2(NIBBLES);
  localparam int unsigned LAST  = NIBBLES - 1;

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [OP_W-1:0]  a_sr;
  logic [OP_W-1:0]  b_sr;
  logic [2:0]       cas;
  logic             busy;
  logic             done;
  logic             eq_out;
  logic             lt_out;
  logic             gt_out;

  logic             lt_c;
  logic             eq_c;
  logic             gt_c;
  logic [2:0]       cas_nxt_c;

  // Compare the nibbles currently at the bottom of the shift registers.
  nibble_cmp4 u_cmp4 (
    .an   (a_sr[NIB_W-1:0]),
    .bn   (b_sr[NIB_W-1:0]),
    .lt_c (lt_c),
    .eq_c (eq_c),
    .gt_c (gt_c)
  );

  // Cascade update: an unequal nibble replaces the carried verdict.
  always_comb begin
    cas_nxt_c = cas;
    if (gt_c) begin
      cas_nxt_c         = 3'b000;
      cas_nxt_c[CAS_GT] = 1'b1;
    end else if (lt_c) begin
      cas_nxt_c         = 3'b000;
      cas_nxt_c[CAS_LT] = 1'b1;
    end else if (eq_c) begin
      cas_nxt_c = cas;
    end
  end

  // Controller, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      a_sr   <= '0;
      b_sr   <= '0;
      cas    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      eq_out <= 1'b0;
      lt_out <= 1'b0;
      gt_out <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            a_sr        <= bus.a;
            b_sr        <= bus.b;
            cas[CAS_LT] <= bus.seed_lt;
            cas[CAS_EQ] <= bus.seed_eq;
            cas[CAS_GT] <= bus.seed_gt;
            cnt         <= '0;
            busy        <= 1'b1;
            state       <= RUN;
          end
        end
        RUN: begin
          cas  <= cas_nxt_c;
          a_sr <= a_sr >> NIB_W;
          b_sr <= b_sr >> NIB_W;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(LAST)) begin
            lt_out <= cas_nxt_c[CAS_LT];
            eq_out <= cas_nxt_c[CAS_EQ];
            gt_out <= cas_nxt_c[CAS_GT];
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.eq_out = eq_out;
  assign bus.lt_out = lt_out;
  assign bus.gt_out = gt_out;

endmodule
